// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared func3 codes, depth default, port selection and access-size helpers
package store_buffer_pkg;
  localparam int SB_DEPTH = 4;
  localparam logic [2:0] F3_SB = 3'd0, F3_SH = 3'd1, F3_SW = 3'd2;
  localparam logic [2:0] F3_LB = 3'd0, F3_LH = 3'd1, F3_LW = 3'd2, F3_LBU = 3'd4, F3_LHU = 3'd5;
  typedef enum logic [1:0] {PORT_IDLE, PORT_LOAD, PORT_DRAIN} port_sel_e;
  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    return f3[1:0] == F3_SW[1:0] ? 3'd4 : f3[1:0] == F3_SH[1:0] ? 3'd2 : 3'd1;
  endfunction
  function automatic logic [31:0] ld_extend(input logic [31:0] d, input logic [2:0] f3);
    logic s;
    s = ~(f3 == F3_LBU || f3 == F3_LHU);
    return f3[1:0] == F3_LW[1:0] ? d : f3[1:0] == F3_LH[1:0] ? {{16{d[15] & s}}, d[15:0]} : {{24{d[7] & s}}, d[7:0]};
  endfunction
endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: CPU store/load port and data-memory port of the store buffer
interface store_buffer_if #(parameter int AW = 32);
  logic st_valid, st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0] st_data;
  logic [2:0] st_func3;
  logic ld_req, ld_stall;
  logic [AW-1:0] ld_addr;
  logic [2:0] ld_func3;
  logic [31:0] ld_data;
  logic empty;
  logic mem_write, mem_read;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_write_data, mem_data_out;
  logic [2:0] mem_func3;
  modport slave (
    input st_valid, st_addr, st_data, st_func3, ld_req, ld_addr, ld_func3, mem_data_out,
    output st_ready, ld_stall, ld_data, empty, mem_write, mem_read, mem_addr, mem_write_data, mem_func3
  );
  modport master (
    output st_valid, st_addr, st_data, st_func3, ld_req, ld_addr, ld_func3, mem_data_out,
    input st_ready, ld_stall, ld_data, empty, mem_write, mem_read, mem_addr, mem_write_data, mem_func3
  );
endinterface

// File: rtl/store_buffer_overlap.sv
// sb_overlap: byte-span overlap and exact-cover test of one buffered store against a load
module sb_overlap
  import store_buffer_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          i_valid,
  input  logic [AW-1:0] i_st_addr,
  input  logic [2:0]    i_st_func3,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [2:0]    i_ld_func3,
  output logic          o_overlap,
  output logic          o_exact_cover
);
  logic [AW:0] w_st_last, w_ld_last;
  assign w_st_last = {1'b0, i_st_addr} + (AW+1)'(f3_size(i_st_func3) - 3'd1);
  assign w_ld_last = {1'b0, i_ld_addr} + (AW+1)'(f3_size(i_ld_func3) - 3'd1);
  assign o_overlap = i_valid & ({1'b0, i_st_addr} <= w_ld_last) & ({1'b0, i_ld_addr} <= w_st_last);
  assign o_exact_cover = o_overlap & (i_st_addr == i_ld_addr) & (f3_size(i_st_func3) >= f3_size(i_ld_func3));
endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO draining to data memory; define STORE_FWD_EN for store-to-load forwarding
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW = 32
) (
  input logic clk,
  input logic rst,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] r_head, r_tail;
  logic [PW:0] r_count;
  logic [AW-1:0] r_addr [DEPTH];
  logic [31:0] r_data [DEPTH];
  logic [2:0] r_func3 [DEPTH];
  logic [DEPTH-1:0] w_ov, w_cover;
  logic w_conflict, w_enq, w_fwd;
  logic [31:0] w_fwd_data;
  port_sel_e w_sel;
  for (genvar g = 0; g < DEPTH; g++) begin : g_ov
    sb_overlap #(.AW(AW)) u_ov (
      .i_valid({1'b0, PW'(g) - r_head} < r_count),
      .i_st_addr(r_addr[g]),
      .i_st_func3(r_func3[g]),
      .i_ld_addr(bus.ld_addr),
      .i_ld_func3(bus.ld_func3),
      .o_overlap(w_ov[g]),
      .o_exact_cover(w_cover[g])
    );
  end
`ifdef STORE_FWD_EN
  // Walk oldest to youngest so the youngest overlapping entry decides; it alone must cover the load
  always_comb begin
    w_fwd = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (w_ov[r_head + PW'(i)]) begin
        w_fwd = w_cover[r_head + PW'(i)];
        w_fwd_data = ld_extend(r_data[r_head + PW'(i)], bus.ld_func3);
      end
    w_fwd = w_fwd & w_conflict;
  end
`else
  logic w_unused;
  assign w_unused = ^w_cover;
  assign w_fwd = 1'b0;
  assign w_fwd_data = '0;
`endif
  assign w_conflict = bus.ld_req & |w_ov;
  assign w_sel = (bus.ld_req & ~w_conflict) ? PORT_LOAD : (r_count != '0) ? PORT_DRAIN : PORT_IDLE;
  assign w_enq = bus.st_valid & bus.st_ready;
  assign bus.st_ready = r_count != (PW+1)'(DEPTH);
  assign bus.empty = r_count == '0;
  assign bus.mem_read = w_sel == PORT_LOAD;
  assign bus.mem_write = w_sel == PORT_DRAIN;
  assign bus.mem_addr = bus.mem_read ? bus.ld_addr : bus.mem_write ? r_addr[r_head] : '0;
  assign bus.mem_write_data = bus.mem_write ? r_data[r_head] : '0;
  assign bus.mem_func3 = bus.mem_read ? bus.ld_func3 : bus.mem_write ? r_func3[r_head] : '0;
  assign bus.ld_stall = w_conflict & ~w_fwd;
  assign bus.ld_data = bus.mem_read ? bus.mem_data_out : w_fwd ? w_fwd_data : '0;
  // Pointer and count bookkeeping; reset discards every buffered store, including one mid-drain
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else begin
      r_tail <= r_tail + PW'(w_enq);
      r_head <= r_head + PW'(bus.mem_write);
      r_count <= r_count + (PW+1)'(w_enq) - (PW+1)'(bus.mem_write);
    end
  // Entry payload needs no reset; validity comes from the pointers
  always_ff @(posedge clk)
    if (w_enq) begin
      r_addr[r_tail] <= bus.st_addr;
      r_data[r_tail] <= bus.st_data;
      r_func3[r_tail] <= bus.st_func3;
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: random and directed checks of store_buffer against a queue-based reference model
module tb_store_buffer;
  import store_buffer_pkg::*;
  localparam int DEPTH = 4;
  localparam int AW = 32;
  localparam logic [103:0] RST_VEC = {2'b11, 102'd0};
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  store_buffer_if #(.AW(AW)) bus();
  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {logic [31:0] a; logic [31:0] d; logic [2:0] f;} st_t;
  st_t q[$];
  st_t e_st;
  logic [7:0] tb_mem [1024] = '{default: 8'h00};
  logic [7:0] ref_mem [1024] = '{default: 8'h00};
  logic [103:0] e_vec, w_obs;
  logic e_enq, e_drain;
  logic allow_dual = 1'b0;
  int n_total = 0, n_bad = 0;
  function automatic int sz(input logic [2:0] f);
    return f[1:0] == 2'd2 ? 4 : f[1:0] == 2'd1 ? 2 : 1;
  endfunction
  function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f);
    case (f)
      3'd0: return {{24{w[7]}}, w[7:0]};
      3'd1: return {{16{w[15]}}, w[15:0]};
      3'd4: return {24'd0, w[7:0]};
      3'd5: return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction
  function automatic bit ovl(input logic [31:0] a, input logic [2:0] af, input logic [31:0] l, input logic [2:0] lf);
    longint sa, sl;
    sa = longint'(a);
    sl = longint'(l);
    return sa <= sl + sz(lf) - 1 && sl <= sa + sz(af) - 1;
  endfunction
  function automatic logic [31:0] raw_ref(input logic [31:0] a);
    return {ref_mem[10'(a + 32'd3)], ref_mem[10'(a + 32'd2)], ref_mem[10'(a + 32'd1)], ref_mem[10'(a)]};
  endfunction
  assign w_obs = {bus.st_ready, bus.empty, bus.ld_stall, bus.mem_read, bus.mem_write, bus.mem_addr,
                  bus.mem_write_data, bus.mem_func3, bus.ld_data};
  assign bus.mem_data_out = ext({tb_mem[10'(bus.mem_addr + 32'd3)], tb_mem[10'(bus.mem_addr + 32'd2)],
                                 tb_mem[10'(bus.mem_addr + 32'd1)], tb_mem[10'(bus.mem_addr)]}, bus.mem_func3);
  always @(posedge clk)
    if (bus.mem_write)
      for (int k = 0; k < sz(bus.mem_func3); k++) tb_mem[10'(bus.mem_addr + 32'(k))] <= bus.mem_write_data[8*k +: 8];
  always @(posedge clk)
    if (!rst) assert (allow_dual || !(bus.st_valid && bus.ld_req)) else $error("store and load issued together");
  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd, input logic [2:0] sf,
                       input logic lr, input logic [31:0] la, input logic [2:0] lf);
    bus.st_valid = sv; bus.st_addr = sa; bus.st_data = sd; bus.st_func3 = sf;
    bus.ld_req = lr; bus.ld_addr = la; bus.ld_func3 = lf;
  endtask
  task automatic predict();
    int y;
    bit sr, em, fwd;
    logic [31:0] fd;
    y = -1; fwd = 0; fd = '0;
    sr = q.size() != DEPTH;
    em = q.size() == 0;
    for (int i = 0; i < q.size(); i++)
      if (bus.ld_req && ovl(q[i].a, q[i].f, bus.ld_addr, bus.ld_func3)) y = i;
`ifdef STORE_FWD_EN
    if (y >= 0 && q[y].a == bus.ld_addr && sz(q[y].f) >= sz(bus.ld_func3)) begin
      fwd = 1;
      fd = ext(q[y].d, bus.ld_func3);
    end
`endif
    e_enq = bus.st_valid && sr;
    e_st = '{bus.st_addr, bus.st_data, bus.st_func3};
    e_drain = 0;
    if (bus.ld_req && y < 0)
      e_vec = {sr, em, 3'b010, bus.ld_addr, 32'd0, bus.ld_func3, ext(raw_ref(bus.ld_addr), bus.ld_func3)};
    else if (!em) begin
      e_drain = 1;
      e_vec = {sr, em, bus.ld_req && !fwd, 2'b01, q[0].a, q[0].d, q[0].f, fd};
    end else
      e_vec = {sr, em, 3'b000, 32'd0, 32'd0, 3'd0, 32'd0};
  endtask
  task automatic commit();
    @(posedge clk);
    #1;
    if (e_drain) begin
      for (int k = 0; k < sz(q[0].f); k++) ref_mem[10'(q[0].a + 32'(k))] = q[0].d[8*k +: 8];
      void'(q.pop_front());
    end
    if (e_enq) q.push_back(e_st);
  endtask
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      predict();
      commit();
    end
  endtask
  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    n_total++;
    if (w_obs !== RST_VEC) begin n_bad++; $display("FAIL reset: got %h want %h", w_obs, RST_VEC); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic test_single_store();
    drive(1, 32'h10, 32'hDEADBEEF, F3_SW, 0, 0, 0);
    #1; predict();
    n_total++;
    if (w_obs !== e_vec) begin n_bad++; $display("FAIL single_enq: got %h want %h", w_obs, e_vec); end
    commit();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1; predict();
    n_total++;
    if ({bus.empty, bus.mem_write, bus.mem_addr, bus.mem_func3} !== {1'b0, 1'b1, 32'h10, F3_SW}) begin
      n_bad++; $display("FAIL single_drain: got e=%b w=%b a=%h f=%0d", bus.empty, bus.mem_write, bus.mem_addr, bus.mem_func3);
    end
    commit();
    #1; predict();
    n_total++;
    if ({bus.empty, bus.mem_write} !== 2'b10) begin n_bad++; $display("FAIL single_empty: got %b want 10", {bus.empty, bus.mem_write}); end
    commit();
    n_total++;
    if ({tb_mem[19], tb_mem[18], tb_mem[17], tb_mem[16]} !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL single_mem: got %h want deadbeef", {tb_mem[19], tb_mem[18], tb_mem[17], tb_mem[16]});
    end
  endtask
  task automatic test_fill_hold();
    allow_dual = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'h20 + 32'(4 * i), 32'hA0 + 32'(i), F3_SW, 1, 32'h100, F3_LW);
      #1; predict();
      n_total++;
      if (w_obs !== e_vec || bus.mem_write !== 1'b0) begin n_bad++; $display("FAIL fill_%0d: got %h want %h", i, w_obs, e_vec); end
      commit();
    end
    drive(0, 0, 0, 0, 1, 32'h100, F3_LW);
    #1; predict();
    n_total++;
    if (w_obs !== e_vec || bus.st_ready !== 1'b0) begin n_bad++; $display("FAIL fill_full: got %h want %h", w_obs, e_vec); end
    commit();
    allow_dual = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      #1; predict();
      n_total++;
      if (w_obs !== e_vec || bus.mem_addr !== 32'h20 + 32'(4 * i) || bus.mem_write_data !== 32'hA0 + 32'(i)) begin
        n_bad++; $display("FAIL fill_drain_%0d: got %h want %h", i, w_obs, e_vec);
      end
      commit();
    end
  endtask
  task automatic test_conflict();
    drive(1, 32'h41, 32'h80, F3_SB, 0, 0, 0);
    #1; predict(); commit();
    drive(0, 0, 0, 0, 1, 32'h40, F3_LW);
    #1; predict();
    n_total++;
    if (w_obs !== e_vec || bus.ld_stall !== 1'b1) begin n_bad++; $display("FAIL conflict_stall: got %h want %h", w_obs, e_vec); end
    commit();
    #1; predict();
    n_total++;
    if (w_obs !== e_vec || {bus.ld_stall, bus.ld_data} !== {1'b0, 32'h00008000}) begin
      n_bad++; $display("FAIL conflict_data: got %h want %h", w_obs, e_vec);
    end
    commit();
  endtask
  task automatic test_no_conflict();
    drive(1, 32'h200, 32'h12345678, F3_SW, 0, 0, 0);
    #1; predict(); commit();
    idle_cycles(1);
    allow_dual = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'h10 + 32'(4 * i), $urandom, F3_SW, 1, 32'h200, F3_LW);
      #1; predict(); commit();
    end
    allow_dual = 1'b0;
    drive(0, 0, 0, 0, 1, 32'h200, F3_LW);
    #1; predict();
    n_total++;
    if (w_obs !== e_vec || {bus.ld_stall, bus.mem_read, bus.mem_write, bus.ld_data} !== {3'b010, 32'h12345678}) begin
      n_bad++; $display("FAIL noconf: got %h want %h", w_obs, e_vec);
    end
    commit();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      #1; predict();
      n_total++;
      if (w_obs !== e_vec) begin n_bad++; $display("FAIL noconf_drain_%0d: got %h want %h", i, w_obs, e_vec); end
      commit();
    end
  endtask
  task automatic test_forward();
    logic [31:0] la [3] = '{32'h30, 32'h30, 32'h31};
    logic [2:0] lf [3] = '{F3_LB, F3_LHU, F3_LB};
    logic [31:0] fv [3] = '{32'hFFFFFFFF, 32'h000080FF, 32'h0};
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h30, 32'h000080FF, F3_SW, 0, 0, 0);
      #1; predict(); commit();
      drive(0, 0, 0, 0, 1, la[i], lf[i]);
      #1; predict();
      n_total++;
      if (w_obs !== e_vec) begin n_bad++; $display("FAIL fwd_model_%0d: got %h want %h", i, w_obs, e_vec); end
`ifdef STORE_FWD_EN
      n_total++;
      if ({bus.ld_stall, bus.mem_write, bus.ld_data} !== {i == 2, 1'b1, fv[i]}) begin
        n_bad++; $display("FAIL fwd_%0d: got stall=%b w=%b d=%h want data %h", i, bus.ld_stall, bus.mem_write, bus.ld_data, fv[i]);
      end
`endif
      commit();
      idle_cycles(DEPTH);
    end
  endtask
  task automatic test_stall_bound();
    int stalls;
    bit done;
    stalls = 0; done = 0;
    allow_dual = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'h70 + 32'(4 * i), $urandom, F3_SW, 1, 32'h100, F3_LW);
      #1; predict(); commit();
    end
    allow_dual = 1'b0;
    drive(0, 0, 0, 0, 1, 32'h7D, F3_LB);
    for (int c = 0; c < DEPTH + 2 && !done; c++) begin
      #1; predict();
      n_total++;
      if (w_obs !== e_vec) begin n_bad++; $display("FAIL bound_%0d: got %h want %h", c, w_obs, e_vec); end
      if (bus.ld_stall) stalls++; else done = 1;
      commit();
    end
    n_total++;
    if (!done || stalls !== DEPTH) begin n_bad++; $display("FAIL bound: got stalls=%0d done=%0b want %0d", stalls, done, DEPTH); end
    idle_cycles(1);
  endtask
  task automatic test_random();
    int r, k;
    logic [2:0] lf;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 9);
      k = $urandom_range(0, 4);
      lf = k < 3 ? 3'(k) : 3'(k + 1);
      drive(r < 4, 32'($urandom_range(0, 127)), $urandom, 3'($urandom_range(0, 2)), r >= 4 && r < 8, 32'($urandom_range(0, 127)), lf);
      #1; predict();
      n_total++;
      if (w_obs !== e_vec) begin n_bad++; $display("FAIL rand_%0d: got %h want %h", c, w_obs, e_vec); end
      commit();
    end
    idle_cycles(DEPTH + 1);
    k = 0;
    for (int a = 0; a < 1024; a++) if (tb_mem[a] !== ref_mem[a]) k++;
    n_total++;
    if (k != 0) begin n_bad++; $display("FAIL rand_mem: got %0d differing bytes want 0", k); end
  endtask
  task automatic test_reset_midflight();
    allow_dual = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h60 + 32'(4 * i), 32'h11111111 * 32'(i + 1), F3_SW, 1, 32'h100, F3_LW);
      #1; predict(); commit();
    end
    allow_dual = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    n_total++;
    if (w_obs !== RST_VEC) begin n_bad++; $display("FAIL midreset: got %h want %h", w_obs, RST_VEC); end
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; predict();
      n_total++;
      if (w_obs !== e_vec) begin n_bad++; $display("FAIL midreset_idle_%0d: got %h want %h", i, w_obs, e_vec); end
      commit();
    end
    n_total++;
    if ({tb_mem[96], tb_mem[100], tb_mem[104], tb_mem[107]} !== 32'd0) begin
      n_bad++; $display("FAIL midreset_mem: got %h want 0", {tb_mem[96], tb_mem[100], tb_mem[104], tb_mem[107]});
    end
  endtask
  initial begin
    test_reset();
    test_single_store();
    test_fill_hold();
    test_conflict();
    test_no_conflict();
    test_forward();
    test_stall_bound();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
